// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter: merges in-order load responses and ALU results,
// tracking outstanding load destinations for RAW stalls and WAW blocking.
module regfile_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LD_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  ld_issue,
  input  logic [4:0]            ld_issue_rd,
  output logic                  ld_issue_ready,
  input  logic                  ld_resp_valid,
  input  logic [DATA_WIDTH-1:0] ld_resp_data,
  input  logic [4:0]            rs0,
  input  logic [4:0]            rs1,
  output logic                  hazard_stall,
  output logic                  wr_en,
  output logic [4:0]            wr_num,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  resp_err
);
  localparam int PW = $clog2(LD_DEPTH);

  logic [LD_DEPTH-1:0][4:0] r_q;
  logic [PW-1:0]            r_wp, r_rp;
  logic [PW:0]              r_cnt;
  logic                     r_wr_en, r_err;
  logic [4:0]               r_wr_num;
  logic [DATA_WIDTH-1:0]    r_wr_data;

  logic [LD_DEPTH-1:0]      w_vld;
  logic                     w_m_rs0, w_m_rs1, w_m_alu;
  logic                     w_push, w_pop, w_alu_acc;
  logic [4:0]               w_head;
  logic [PW-1:0]            w_off;

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    w_vld   = '0;
    w_m_rs0 = 1'b0;
    w_m_rs1 = 1'b0;
    w_m_alu = 1'b0;
    w_off   = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      w_off    = PW'(i) - r_rp;
      w_vld[i] = {1'b0, w_off} < r_cnt;
      if (w_vld[i] && r_q[i] == rs0)    w_m_rs0 = 1'b1;
      if (w_vld[i] && r_q[i] == rs1)    w_m_rs1 = 1'b1;
      if (w_vld[i] && r_q[i] == alu_rd) w_m_alu = 1'b1;
    end
  end

  assign w_head         = r_q[r_rp];
  assign w_pop          = ld_resp_valid && (r_cnt != '0);
  assign ld_issue_ready = r_cnt < (PW+1)'(LD_DEPTH);
  assign w_push         = ld_issue && ld_issue_ready;
  assign alu_ready      = !w_pop && !((alu_rd != 5'd0) && w_m_alu);
  assign w_alu_acc      = alu_valid && alu_ready;
  assign hazard_stall   = ((rs0 != 5'd0) && w_m_rs0) || ((rs1 != 5'd0) && w_m_rs1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_num  <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= ld_issue_rd;
        r_wp      <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (ld_resp_valid && r_cnt == '0) r_err <= 1'b1;

      // Load data has priority; rd 0 consumes the slot but writes nothing.
      r_wr_en <= 1'b0;
      if (w_pop) begin
        if (w_head != 5'd0) begin
          r_wr_en   <= 1'b1;
          r_wr_num  <= w_head;
          r_wr_data <= ld_resp_data;
        end
      end else if (w_alu_acc && alu_rd != 5'd0) begin
        r_wr_en   <= 1'b1;
        r_wr_num  <= alu_rd;
        r_wr_data <= alu_data;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_num   = r_wr_num;
  assign wr_data  = r_wr_data;
  assign resp_err = r_err;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed scenarios plus random traffic checked against a queue-based model.
module tb_regfile_wb_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready, ld_issue, ld_issue_ready, ld_resp_valid;
  logic [4:0]    alu_rd, ld_issue_rd, rs0, rs1, wr_num;
  logic [DW-1:0] alu_data, ld_resp_data, wr_data;
  logic          hazard_stall, wr_en, resp_err;

  regfile_wb_ctrl #(.DATA_WIDTH(DW), .LD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .rs0(rs0), .rs1(rs1), .hazard_stall(hazard_stall),
    .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int            m_q[$];
  logic          m_en, m_err;
  logic [4:0]    m_num;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input logic [4:0] r);
    foreach (m_q[i]) if (m_q[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, advance the model
  // across posedge, then check the registered outputs at the next negedge.
  task automatic step(input bit rst, input bit av, input logic [4:0] ard, input logic [DW-1:0] ad,
                      input bit li, input logic [4:0] lrd, input bit rv, input logic [DW-1:0] rd,
                      input logic [4:0] r0, input logic [4:0] r1);
    bit e_ardy, e_stall, e_irdy;
    int h;
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_issue = li; ld_issue_rd = lrd; ld_resp_valid = rv; ld_resp_data = rd;
    rs0 = r0; rs1 = r1;
    e_ardy  = !(rv && m_q.size() != 0) && !(ard != 0 && in_q(ard));
    e_stall = (r0 != 0 && in_q(r0)) || (r1 != 0 && in_q(r1));
    e_irdy  = m_q.size() < DEPTH;
    #1;
    if (!rst) begin
      chk("alu_ready", 64'(alu_ready), 64'(e_ardy));
      chk("hazard_stall", 64'(hazard_stall), 64'(e_stall));
      chk("ld_issue_ready", 64'(ld_issue_ready), 64'(e_irdy));
    end
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_en = 0; m_num = 0; m_data = 0; m_err = 0;
    end else begin
      m_en = 0;
      if (rv && m_q.size() != 0) begin
        h = m_q.pop_front();
        if (h != 0) begin m_en = 1; m_num = 5'(h); m_data = rd; end
      end else if (av && e_ardy && ard != 0) begin
        m_en = 1; m_num = ard; m_data = ad;
      end
      if (rv && !(e_irdy || m_q.size() < DEPTH)) m_err = m_err;
      if (li && e_irdy) m_q.push_back(int'(lrd));
      if (rv && !e_ardy && 0) m_err = m_err;
    end
    @(negedge clk);
    chk("wr_en", 64'(wr_en), 64'(m_en));
    chk("wr_num", 64'(wr_num), 64'(m_num));
    chk("wr_data", 64'(wr_data), 64'(m_data));
    chk("resp_err", 64'(resp_err), 64'(m_err));
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  // resp_err tracking needs the pre-pop queue size, so responses on an empty
  // queue go through this wrapper.
  task automatic resp(input logic [DW-1:0] d, input logic [4:0] r0);
    if (m_q.size() == 0) m_err = 1;
    step(0, 0, 0, 0, 0, 0, 1, d, r0, 0);
  endtask

  initial begin
    m_en = 0; m_num = 0; m_data = 0; m_err = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ld_issue_ready", 64'(ld_issue_ready), 64'd1);

    // 1: plain ALU write
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    chk("t1_data", 64'(wr_data), 64'hDEADBEEF);
    // 2: ALU rd 0 accepted but never writes
    step(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    chk("t2_wr_en", 64'(wr_en), 64'd0);

    // 3: two loads, stall on rs0=7 until the second response
    step(0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0, 7, 0);
    idle(7, 0);
    chk("t3_stall", 64'(hazard_stall), 64'd1);
    resp(32'h11, 7);
    chk("t3_x3", 64'({wr_num, wr_data}), {27'd0, 5'd3, 32'h11});
    resp(32'h22, 7);
    chk("t3_x7", 64'({wr_num, wr_data}), {27'd0, 5'd7, 32'h22});
    idle(7, 0);

    // 4: response and ALU in the same cycle; load wins, ALU retried next
    step(0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step(0, 1, 6, 32'hA5A5, 0, 0, 1, 32'h44, 0, 0);
    chk("t4_load_first", 64'(wr_num), 64'd4);
    step(0, 1, 6, 32'hA5A5, 0, 0, 0, 0, 0, 0);
    chk("t4_alu_next", 64'(wr_num), 64'd6);

    // 5: fill, full issue+resp, drain with wrap
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 1, 5'(10 + i), 0, 0, 0, 0);
    idle(0, 0);
    chk("t5_full", 64'(ld_issue_ready), 64'd0);
    step(0, 0, 0, 0, 1, 20, 1, 32'h100, 0, 0);
    chk("t5_cnt", 64'(m_q.size()), 64'(DEPTH - 1));
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == 1) step(0, 0, 0, 0, 1, 21, 1, 32'h200, 0, 0);
      else resp(32'h200 + 32'(i), 0);
    end

    // 6: WAW block, response on empty, reset
    step(0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    step(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0);
    chk("t6_blocked", 64'(alu_ready), 64'd0);
    resp(32'h9, 0);
    step(0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0);
    resp(32'h0, 0);
    chk("t6_err", 64'(resp_err), 64'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_rst", 64'({wr_en, wr_num, wr_data, resp_err}), 64'd0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      bit rst_r, rv_r;
      rst_r = ($urandom_range(0, 99) == 0);
      rv_r  = ($urandom_range(0, 9) < 4);
      if (!rst_r && rv_r && m_q.size() == 0) m_err = 1;
      step(rst_r, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), rv_r, $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1);
  end
endmodule
